// File: rtl/cache_pkg.sv
// Shared cache constants and the way-hit response record.
// The response record is sized by CACHE_WAYS; instances must keep WAYS equal to it.
package cache_pkg;

  localparam int CACHE_WAYS     = 4;
  localparam int CACHE_TAG_BITS = 20;
  localparam int CACHE_IDX_BITS = 6;
  localparam int RSP_DEPTH      = 3;

  typedef struct packed {
    logic [CACHE_WAYS-1:0] sel;
    logic                  hit;
    logic                  multihit;
  } rsp_t;

  function automatic int unsigned popcount(input logic [CACHE_WAYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CACHE_WAYS; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/way_hit_detect_if.sv
// Lookup request, tag-RAM and response signals of way_hit_detect bundled as one bus.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the producer holds data stable while valid && !ready.
interface way_hit_detect_if
  import cache_pkg::*;
#(
  parameter int WAYS     = CACHE_WAYS,
  parameter int TAG_BITS = CACHE_TAG_BITS,
  parameter int IDX_BITS = CACHE_IDX_BITS
) ();

  logic                req_valid;
  logic                req_ready;
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic                tag_rd_en;
  logic [IDX_BITS-1:0] tag_rd_idx;
  logic [TAG_BITS-1:0] way_tags [WAYS];
  logic [WAYS-1:0]     way_valid;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WAYS-1:0]     sel;
  logic                hit;
  logic                multihit;
  logic                err_multihit;

  modport master (
    output req_valid, req_tag, req_idx, way_tags, way_valid, rsp_ready,
    input  req_ready, tag_rd_en, tag_rd_idx, rsp_valid, sel, hit, multihit, err_multihit
  );

  modport slave (
    input  req_valid, req_tag, req_idx, way_tags, way_valid, rsp_ready,
    output req_ready, tag_rd_en, tag_rd_idx, rsp_valid, sel, hit, multihit, err_multihit
  );

endinterface

// File: rtl/way_hit_fifo.sv
// Small circular response buffer; pointers wrap modulo DEPTH so DEPTH need not be a power of two.
// Caller never pushes when full nor pops when empty.
module way_hit_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (i_pop) rd_ptr_d = next_ptr(rd_ptr_q);
    count_d = count_q + CW'(i_push) - CW'(i_pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/way_hit_detect.sv
// Tag compare and one-hot way select: request -> tag-RAM read -> S1 compare -> 3-entry response FIFO.
// Define WAY_HIT_MULTIHIT_CHK_EN to enable multi-hit detection and the sticky multi-hit error flag.
module way_hit_detect
  import cache_pkg::*;
#(
  parameter int WAYS     = CACHE_WAYS,
  parameter int TAG_BITS = CACHE_TAG_BITS,
  parameter int IDX_BITS = CACHE_IDX_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [TAG_BITS-1:0] i_req_tag,
  input  logic [IDX_BITS-1:0] i_req_idx,
  output logic                o_tag_rd_en,
  output logic [IDX_BITS-1:0] o_tag_rd_idx,
  input  logic [TAG_BITS-1:0] i_way_tags [WAYS],
  input  logic [WAYS-1:0]     i_way_valid,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WAYS-1:0]     o_sel,
  output logic                o_hit,
  output logic                o_multihit,
  output logic                o_err_multihit
);

  logic                req_acc;
  logic                s1_valid_q, s1_valid_d;
  logic [TAG_BITS-1:0] s1_tag_q, s1_tag_d;
  logic [WAYS-1:0]     hit_vec;
  logic [WAYS-1:0]     sel_s1;
  logic                hit_s1;
  logic                mh_s1;
  rsp_t                push_data;
  rsp_t                head;
  logic [1:0]          fifo_count;
  logic                rsp_valid;
  logic                pop;

  // Ready looks only at flops: an S1 result always has a free FIFO slot to land in.
  assign o_req_ready  = ({1'b0, fifo_count} + {2'b00, s1_valid_q}) < 3'd3;
  assign req_acc      = i_req_valid && o_req_ready;
  assign o_tag_rd_en  = req_acc;
  assign o_tag_rd_idx = i_req_idx;

  always_comb begin
    s1_valid_d = req_acc;
    s1_tag_d   = req_acc ? i_req_tag : s1_tag_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = i_way_valid[w] && (i_way_tags[w] == s1_tag_q);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign sel_s1 = hit_vec & (~hit_vec + WAYS'(1));
  assign hit_s1 = |hit_vec;

`ifdef WAY_HIT_MULTIHIT_CHK_EN
  assign mh_s1 = popcount(hit_vec) > 1;
`else
  assign mh_s1 = 1'b0;
`endif

  always_comb begin
    push_data          = '0;
    push_data.sel      = sel_s1;
    push_data.hit      = hit_s1;
    push_data.multihit = mh_s1;
  end

  way_hit_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (s1_valid_q),
    .i_push_data (push_data),
    .i_pop       (pop),
    .o_head      (head),
    .o_count     (fifo_count)
  );

  assign rsp_valid   = (fifo_count != 2'd0);
  assign pop         = rsp_valid && i_rsp_ready;
  assign o_rsp_valid = rsp_valid;
  assign o_sel       = rsp_valid ? head.sel : '0;
  assign o_hit       = rsp_valid && head.hit;

`ifdef WAY_HIT_MULTIHIT_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (pop && head.multihit);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_multihit     = rsp_valid && head.multihit;
  assign o_err_multihit = err_q;
`else
  logic unused_multihit;
  assign unused_multihit = head.multihit;
  assign o_multihit      = 1'b0;
  assign o_err_multihit  = 1'b0;
`endif

endmodule

// File: tb/tb_way_hit_detect.sv
// Self-checking bench for way_hit_detect: synchronous tag-RAM model, expected-response queue, directed and random lookups.
module tb_way_hit_detect;
  import cache_pkg::*;

  localparam int WAYS = CACHE_WAYS;
  localparam int TB   = CACHE_TAG_BITS;
  localparam int IB   = CACHE_IDX_BITS;
  localparam int RW   = WAYS + 2;
`ifdef WAY_HIT_MULTIHIT_CHK_EN
  localparam bit MH_EN = 1'b1;
`else
  localparam bit MH_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  way_hit_detect_if #(.WAYS(WAYS), .TAG_BITS(TB), .IDX_BITS(IB)) bus ();

  way_hit_detect #(.WAYS(WAYS), .TAG_BITS(TB), .IDX_BITS(IB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (bus.req_valid),
    .o_req_ready    (bus.req_ready),
    .i_req_tag      (bus.req_tag),
    .i_req_idx      (bus.req_idx),
    .o_tag_rd_en    (bus.tag_rd_en),
    .o_tag_rd_idx   (bus.tag_rd_idx),
    .i_way_tags     (bus.way_tags),
    .i_way_valid    (bus.way_valid),
    .o_rsp_valid    (bus.rsp_valid),
    .i_rsp_ready    (bus.rsp_ready),
    .o_sel          (bus.sel),
    .o_hit          (bus.hit),
    .o_multihit     (bus.multihit),
    .o_err_multihit (bus.err_multihit)
  );

  // ---------------- tag RAM model (one-cycle read) ----------------
  logic [TB-1:0]   ram_tags [64][WAYS];
  logic [WAYS-1:0] ram_valid [64];
  logic [IB-1:0]   rd_idx_q;

  always @(posedge clk) rd_idx_q <= bus.tag_rd_idx;

  always_comb begin
    for (int w = 0; w < WAYS; w++) bus.way_tags[w] = ram_tags[rd_idx_q][w];
    bus.way_valid = ram_valid[rd_idx_q];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accepted = 0;
  int popped   = 0;
  bit chk_lat  = 1'b0;
  bit err_exp  = 1'b0;
  logic [RW-1:0] exp_q [$];
  int            lat_q [$];
  logic [RW-1:0] mon_e;
  int            mon_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [TB-1:0] tag, input logic [IB-1:0] idx);
    logic [WAYS-1:0] s;
    bit found;
    int n;
    s = '0;
    found = 1'b0;
    n = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (ram_valid[idx][w] && ram_tags[idx][w] == tag) begin
        n++;
        if (!found) begin
          s[w]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return {s, (n > 0), (MH_EN && n > 1)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_when_idle", bus.rsp_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          popped++;
          check_eq("rsp_sel", bus.sel, mon_e[RW-1:2]);
          check_eq("rsp_hit", bus.hit, mon_e[1]);
          check_eq("rsp_multihit", bus.multihit, mon_e[0]);
          if (mon_l >= 0) check_eq("rsp_latency", cyc - mon_l, 2);
          if (mon_e[0]) err_exp = 1'b1;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(model(bus.req_tag, bus.req_idx));
        lat_q.push_back(chk_lat ? cyc : -1);
        accepted++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [TB-1:0] tag, input logic [IB-1:0] idx);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    bus.req_idx   = idx;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
  endtask

  // Holds the request for up to budget cycles; ok reports whether it was taken.
  task automatic offer(input logic [TB-1:0] tag, input logic [IB-1:0] idx, input int budget, output bit ok);
    ok = 1'b0;
    drive_req(tag, idx);
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready;
      tick();
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [TB-1:0] t;
    logic [IB-1:0] ix;
    logic [TB-1:0] r_tag [4];
    logic [IB-1:0] r_idx [4];
    bit ok;
    int acc0;
    int pop0;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_tag   = '0;
    bus.req_idx   = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      for (int w = 0; w < WAYS; w++) ram_tags[i][w] = TB'($urandom_range(0, 32'h000F_FFFF));
      ram_valid[i] = WAYS'($urandom_range(0, 15));
    end
    ram_tags[1][0] = 20'h11111; ram_tags[1][1] = 20'h22222;
    ram_tags[1][2] = 20'h12345; ram_tags[1][3] = 20'h33333; ram_valid[1] = 4'b0100;
    ram_tags[2][0] = 20'h00001; ram_tags[2][1] = 20'h0ABCD;
    ram_tags[2][2] = 20'h00002; ram_tags[2][3] = 20'h00003; ram_valid[2] = 4'b1101;
    ram_tags[3][0] = 20'h00001; ram_tags[3][1] = 20'h55555;
    ram_tags[3][2] = 20'h00002; ram_tags[3][3] = 20'h55555; ram_valid[3] = 4'b1111;

    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_sel", bus.sel, 0);
    check_eq("rst_hit", bus.hit, 0);
    check_eq("rst_multihit", bus.multihit, 0);
    check_eq("rst_err", bus.err_multihit, 0);
    check_eq("rst_req_ready", bus.req_ready, 1);
    tick();

    // single hit in way 2
    drive_req(20'h12345, 6'd1);
    #1;
    check_eq("rd_en", bus.tag_rd_en, 1);
    check_eq("rd_idx", bus.tag_rd_idx, 1);
    tick();
    idle_req();
    tick();
    check_eq("hit_w2_valid", bus.rsp_valid, 1);
    check_eq("hit_w2_sel", bus.sel, 4'b0100);
    check_eq("hit_w2_hit", bus.hit, 1);
    wait_drain(10);

    // tag matches an invalid way
    drive_req(20'h0ABCD, 6'd2);
    tick();
    idle_req();
    tick();
    check_eq("inv_way_valid", bus.rsp_valid, 1);
    check_eq("inv_way_sel", bus.sel, 0);
    check_eq("inv_way_hit", bus.hit, 0);
    wait_drain(10);

    // ways 1 and 3 both match
    drive_req(20'h55555, 6'd3);
    tick();
    idle_req();
    tick();
    check_eq("mh_sel", bus.sel, 4'b0010);
    check_eq("mh_hit", bus.hit, 1);
    check_eq("mh_multihit", bus.multihit, 32'(MH_EN));
    tick();
    check_eq("mh_err_set", bus.err_multihit, 32'(MH_EN));
    repeat (3) tick();
    check_eq("mh_err_held", bus.err_multihit, 32'(MH_EN));
    wait_drain(10);

    // 10 back-to-back lookups, consumer always ready
    chk_lat = 1'b1;
    pop0 = popped;
    for (int k = 0; k < 10; k++) begin
      ix = IB'($urandom_range(4, 63));
      if ($urandom_range(0, 1) == 1) t = ram_tags[ix][$urandom_range(0, WAYS-1)];
      else t = TB'($urandom_range(0, 32'h000F_FFFF));
      drive_req(t, ix);
      @(negedge clk);
      check_eq("b2b_ready", bus.req_ready, 1);
      tick();
    end
    idle_req();
    wait_drain(20);
    chk_lat = 1'b0;
    check_eq("b2b_count", popped - pop0, 10);

    // backpressure: 4 offered, 3 taken
    bus.rsp_ready = 1'b0;
    acc0 = accepted;
    for (int k = 0; k < 4; k++) begin
      r_idx[k] = IB'($urandom_range(4, 63));
      r_tag[k] = ram_tags[r_idx[k]][k % WAYS];
    end
    for (int k = 0; k < 3; k++) offer(r_tag[k], r_idx[k], 1, ok);
    offer(r_tag[3], r_idx[3], 3, ok);
    check_eq("bp_4th_blocked", ok, 0);
    check_eq("bp_accepted", accepted - acc0, 3);
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_ready_low", bus.req_ready, 0);
      check_eq("bp_head_valid", bus.rsp_valid, 1);
      check_eq("bp_head_sel", bus.sel, exp_q[0][RW-1:2]);
      check_eq("bp_head_hit", bus.hit, exp_q[0][1]);
      tick();
    end
    bus.rsp_ready = 1'b1;
    offer(r_tag[3], r_idx[3], 10, ok);
    idle_req();
    check_eq("bp_4th_taken", ok, 1);
    wait_drain(20);
    check_eq("bp_total", accepted - acc0, 4);
    check_eq("err_before_rst", bus.err_multihit, 32'(err_exp));

    // reset with two results buffered
    bus.rsp_ready = 1'b0;
    offer(20'h12345, 6'd1, 1, ok);
    offer(20'h0ABCD, 6'd2, 1, ok);
    idle_req();
    tick();
    check_eq("pre_rst_valid", bus.rsp_valid, 1);
    pop0 = popped;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", bus.rsp_valid, 0);
    check_eq("async_rst_sel", bus.sel, 0);
    check_eq("async_rst_hit", bus.hit, 0);
    exp_q.delete();
    lat_q.delete();
    err_exp = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", bus.req_ready, 1);
    check_eq("post_rst_err", bus.err_multihit, 0);
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
    check_eq("no_stale_rsp", popped - pop0, 0);

    // lookup after reset works normally
    offer(20'h12345, 6'd1, 3, ok);
    idle_req();
    check_eq("post_rst_accept", ok, 1);
    wait_drain(10);
    check_eq("post_rst_pops", popped - pop0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/way_hit_detect.md
WAY_HIT_DETECT -- requirements
Module: way_hit_detect

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: i_clk, i_rst.
REQ-002 SHALL have parameter WAYS, default 4: number of ways; one-hot select width.
REQ-003 SHALL have parameter TAG_BITS, default 20: tag width.
REQ-004 SHALL have parameter IDX_BITS, default 6: set index width.
REQ-005 SHALL have port i_clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port i_req_valid  in  1  lookup request valid.
REQ-008 SHALL have port o_req_ready  out  1  lookup request accepted when high with i_req_valid.
REQ-009 SHALL have port i_req_tag  in  TAG_BITS  tag of the lookup address.
REQ-010 SHALL have port i_req_idx  in  IDX_BITS  set index of the lookup address.
REQ-011 SHALL have port o_tag_rd_en  out  1  tag-RAM read strobe.
REQ-012 SHALL have port o_tag_rd_idx  out  IDX_BITS  tag-RAM read address.
REQ-013 SHALL have port i_way_tags  in  TAG_BITS x WAYS (unpacked)  tag-RAM read data, one entry per way.
REQ-014 SHALL have port i_way_valid  in  WAYS  per-way valid bits from the tag RAM.
REQ-015 SHALL have port o_rsp_valid  out  1  lookup result valid.
REQ-016 SHALL have port i_rsp_ready  in  1  consumer (way data mux stage) accepts the result.
REQ-017 SHALL have port o_sel  out  WAYS  one-hot hit way; all-zero on miss; drives the way mux select.
REQ-018 SHALL have port o_hit  out  1  lookup hit.
REQ-019 SHALL have port o_multihit  out  1  more than one way matched for this result.
REQ-020 SHALL have port o_err_multihit  out  1  sticky multi-hit error flag.

Function
REQ-021 SHALL accept a request in any cycle where i_req_valid && o_req_ready; o_tag_rd_en = i_req_valid && o_req_ready; o_tag_rd_idx = i_req_idx (combinational).
REQ-022 SHALL register the accepted tag into stage S1 (s1_valid=1); the tag RAM returns i_way_tags/i_way_valid exactly one cycle after the strobe, in S1's cycle.
REQ-023 SHALL in S1 compute hit_vec[w] = i_way_valid[w] && (i_way_tags[w] == s1_tag) for each w.
REQ-024 SHALL form o_sel as the lowest-indexed set bit of hit_vec (always one-hot or zero); o_hit = |hit_vec; o_multihit = popcount(hit_vec) > 1.
REQ-025 SHALL push {sel, hit, multihit} from S1 unconditionally into a 3-entry response FIFO at the end of the S1 cycle; S1 never stalls.
REQ-026 SHALL drive o_req_ready = (fifo_count + s1_valid) < 3, from registered state only; no combinational path from i_rsp_ready.
REQ-027 SHALL present the FIFO head on o_sel/o_hit/o_multihit with o_rsp_valid = (fifo_count != 0); pop on o_rsp_valid && i_rsp_ready.
REQ-028 SHALL have a latency of 2 cycles from acceptance (cycle N) to o_rsp_valid (cycle N+2), and sustain 1 lookup/cycle while i_rsp_ready=1.
REQ-029 SHALL allow push and pop in the same cycle with count unchanged; the result SHALL be held stable while o_rsp_valid && !i_rsp_ready.
REQ-030 SHALL keep responses in request order; FIFO pointers wrap modulo 3.

Reset
REQ-031 SHALL on i_rst clear s1_valid, the FIFO count and pointers, and o_err_multihit, asynchronously.
REQ-032 SHALL drive o_rsp_valid=0, o_sel=0, o_hit=0, o_multihit=0, o_err_multihit=0 and o_req_ready=1 after reset; in-flight lookups are discarded.

Configuration
REQ-033 SHALL, with WAY_HIT_MULTIHIT_CHK_EN defined, compute o_multihit per REQ-024 and set o_err_multihit on the first popped response with multihit=1, holding it until reset.
REQ-034 SHALL, without WAY_HIT_MULTIHIT_CHK_EN, tie o_multihit and o_err_multihit to 0 and omit the popcount logic; the port list is unchanged.

Structure
REQ-035 SHALL take WAYS, TAG_BITS, IDX_BITS defaults and the response typedef {sel, hit, multihit} from the shared package cache_pkg.
REQ-036 SHALL implement the response buffer as the sub-module way_hit_fifo (depth 3, width WAYS+2).

Verification
REQ-037 Bench SHALL check: tag 0x12345 in way 2 only, valid=4'b0100 -> o_sel=4'b0100, o_hit=1 at N+2.
REQ-038 Bench SHALL check: tag matches way 1 with valid=4'b1101 -> o_sel=0, o_hit=0.
REQ-039 Bench SHALL check, macro on: ways 1 and 3 match -> o_sel=4'b0010, o_multihit=1, o_err_multihit=1 after pop and held; macro off -> both 0.
REQ-040 Bench SHALL check: 10 back-to-back requests with i_rsp_ready=1 -> 10 in-order responses on consecutive cycles, o_req_ready never low.
REQ-041 Bench SHALL check: i_rsp_ready=0 with 4 requests offered -> 3 accepted, then o_req_ready=0, head stable; release -> drains in order.
REQ-042 Bench SHALL check: i_rst asserted with 2 results buffered -> o_rsp_valid=0 immediately, o_req_ready=1 next edge, no stale responses.
